// File: rtl/spad_read_sequencer.sv
// spad_read_sequencer: streams (filter, ifmap) operand pairs from PE scratchpads to the MAC
// with credit-gated reads and a 2-entry skid FIFO that absorbs the 1-cycle spad latency.
module spad_read_sequencer #(
  parameter int DATA_W = 8,
  parameter int FILT_LEN = 3,
  parameter int NUM_OUT = 5,
  parameter int STRIDE = 1,
  parameter int IF_DEPTH = 8,
  localparam int FA_W = FILT_LEN > 1 ? $clog2(FILT_LEN) : 1,
  localparam int IA_W = IF_DEPTH > 1 ? $clog2(IF_DEPTH) : 1
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              start,
  input  logic              filt_loaded,
  input  logic [IA_W:0]     if_wr_count,
  output logic              rd_en,
  output logic [FA_W-1:0]   filt_raddr,
  output logic [IA_W-1:0]   if_raddr,
  input  logic [DATA_W-1:0] filt_rdata,
  input  logic [DATA_W-1:0] if_rdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_filt,
  output logic [DATA_W-1:0] out_ifmap,
  output logic              out_last_k,
  output logic              out_last,
  output logic              busy,
  output logic              done
);
  localparam int OW = NUM_OUT > 1 ? $clog2(NUM_OUT) : 1;
  localparam int IW = IA_W + 1;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
  state_t state;
  logic [FA_W-1:0] k;
  logic [OW-1:0] o;
  logic [IW-1:0] idx;
  logic inflight, p_last_k, p_last, last_k, last_o, pop, wp, rp;
  logic [1:0] cnt;
  logic [2*DATA_W+1:0] mem [2];
  assign idx = IW'(o) * IW'(STRIDE) + IW'(k);
  assign last_k = k == FA_W'(FILT_LEN - 1);
  assign last_o = o == OW'(NUM_OUT - 1);
  assign out_valid = cnt != 2'd0;
  assign pop = out_valid && out_ready;
  // A pop this cycle frees a slot in time for the data this read returns next cycle.
  assign rd_en = state == RUN && idx < if_wr_count && 3'(cnt) + 3'(inflight) <= 3'd1 + 3'(pop);
  assign filt_raddr = k;
  assign if_raddr = idx[IA_W-1:0];
  assign {out_filt, out_ifmap, out_last_k, out_last} = mem[rp];
  assign busy = state != IDLE;
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state <= IDLE;
      k <= '0;
      o <= '0;
      inflight <= 1'b0;
      p_last_k <= 1'b0;
      p_last <= 1'b0;
      wp <= 1'b0;
      rp <= 1'b0;
      cnt <= 2'd0;
      done <= 1'b0;
      mem[0] <= '0;
      mem[1] <= '0;
    end else begin
      done <= 1'b0;
      inflight <= rd_en;
      p_last_k <= last_k;
      p_last <= last_k && last_o;
      if (inflight) begin
        mem[wp] <= {filt_rdata, if_rdata, p_last_k, p_last};
        wp <= ~wp;
      end
      if (pop) rp <= ~rp;
      cnt <= cnt + 2'(inflight) - 2'(pop);
      if (state == IDLE && start && filt_loaded) state <= RUN;
      if (rd_en) begin
        k <= last_k ? '0 : k + FA_W'(1);
        if (last_k) o <= last_o ? '0 : o + OW'(1);
        if (last_k && last_o) state <= DRAIN;
      end
      if (state == DRAIN && cnt == 2'd0 && !inflight) begin
        state <= IDLE;
        done <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_spad_read_sequencer.sv
// tb_spad_read_sequencer: two configurations (default and stride-2) driven together and
// checked pair-by-pair against a window-enumeration model of the expected operand stream.
module tb_spad_read_sequencer;
  logic clk = 1'b0;
  logic rstn, start, filt_loaded, rmode;
  logic ordy = 1'b1;
  logic [3:0] wrc;
  logic [1:0] rd, ov, olk, ol, bsy, dn;
  logic [1:0][7:0] ofl, oif, frd, ird;
  logic [1:0][2:0] ia;
  logic [1:0] fa_a;
  logic fa_b;
  logic [7:0] fmem [2][4];
  logic [7:0] imem [2][8];
  int checks = 0, errors = 0, cyc = 0;
  int pc [2], dcnt [2], nlog [2], t0 [2], t1 [2];
  int ilog [2][16], flog [2][16];
  logic [15:0] lkm [2];
  logic stall [2];
  logic [17:0] prev [2];

  always #5 clk = ~clk;

  spad_read_sequencer dut_a (
    .clk(clk), .rstn(rstn), .start(start), .filt_loaded(filt_loaded), .if_wr_count(wrc),
    .rd_en(rd[0]), .filt_raddr(fa_a), .if_raddr(ia[0]), .filt_rdata(frd[0]), .if_rdata(ird[0]),
    .out_valid(ov[0]), .out_ready(ordy), .out_filt(ofl[0]), .out_ifmap(oif[0]),
    .out_last_k(olk[0]), .out_last(ol[0]), .busy(bsy[0]), .done(dn[0]));

  spad_read_sequencer #(.DATA_W(8), .FILT_LEN(2), .NUM_OUT(3), .STRIDE(2), .IF_DEPTH(8)) dut_b (
    .clk(clk), .rstn(rstn), .start(start), .filt_loaded(filt_loaded), .if_wr_count(wrc),
    .rd_en(rd[1]), .filt_raddr(fa_b), .if_raddr(ia[1]), .filt_rdata(frd[1]), .if_rdata(ird[1]),
    .out_valid(ov[1]), .out_ready(ordy), .out_filt(ofl[1]), .out_ifmap(oif[1]),
    .out_last_k(olk[1]), .out_last(ol[1]), .busy(bsy[1]), .done(dn[1]));

  always @(posedge clk) begin
    if (rd[0]) begin frd[0] <= fmem[0][fa_a]; ird[0] <= imem[0][ia[0]]; end
    if (rd[1]) begin frd[1] <= fmem[1][fa_b]; ird[1] <= imem[1][ia[1]]; end
  end

  always @(posedge clk) begin
    #1;
    ordy = rmode ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  function automatic int fl(int i); return i == 0 ? 3 : 2; endfunction
  function automatic int st(int i); return i == 0 ? 1 : 2; endfunction
  function automatic int tot(int i); return i == 0 ? 15 : 6; endfunction

  // Pair n of a pass is tap k of output window o: filter[k] against ifmap[o*STRIDE+k].
  function automatic logic [17:0] expv(int i, int n);
    int f = fl(i);
    int o = n / f;
    int k = n % f;
    return {fmem[i][k], imem[i][o * st(i) + k], 1'(k == f - 1), 1'(n == tot(i) - 1)};
  endfunction

  task automatic chk(input bit ok, input string nm, input int act, input int exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    cyc++;
    for (int i = 0; i < 2; i++) begin
      logic [17:0] cur;
      cur = {ofl[i], oif[i], olk[i], ol[i]};
      if (!rstn) begin
        pc[i] = 0; stall[i] = 1'b0; nlog[i] = 0; lkm[i] = '0;
      end else begin
        if (rd[i]) begin
          chk(int'(ia[i]) < int'(wrc), "credit", int'(ia[i]), int'(wrc));
          if (nlog[i] < 16) begin
            ilog[i][nlog[i]] = int'(ia[i]);
            flog[i][nlog[i]] = i == 0 ? int'(fa_a) : int'(fa_b);
            nlog[i]++;
          end
        end
        if (stall[i]) chk(ov[i] && cur == prev[i], "hold", int'(cur), int'(prev[i]));
        if (ov[i]) begin
          if (pc[i] >= tot(i)) chk(1'b0, "extra_pair", pc[i], tot(i));
          else chk(cur == expv(i, pc[i]), "pair", int'(cur), int'(expv(i, pc[i])));
          if (ordy) begin
            if (pc[i] == 0) t0[i] = cyc;
            if (pc[i] == tot(i) - 1) t1[i] = cyc;
            if (pc[i] < 16) lkm[i][pc[i]] = olk[i];
            pc[i]++;
          end
        end
        stall[i] = ov[i] && !ordy;
        prev[i] = cur;
        if (dn[i]) begin
          chk(!bsy[i] && pc[i] == tot(i), "done_pairs", pc[i], tot(i));
          dcnt[i]++;
          pc[i] = 0;
        end
      end
    end
  end

  task automatic tick; @(posedge clk); #1; endtask

  task automatic newmem;
    int b = int'($urandom_range(0, 255));
    for (int i = 0; i < 2; i++) begin
      for (int j = 0; j < 4; j++) fmem[i][j] = 8'($urandom);
      for (int j = 0; j < 8; j++) imem[i][j] = 8'(j * 29 + b + i);
    end
  endtask

  task automatic run_pass(input bit ramp, input bit restart_busy);
    int d0 = dcnt[0];
    int d1 = dcnt[1];
    int n = 0;
    filt_loaded = 1'b1;
    start = 1'b1;
    tick;
    start = 1'b0;
    while (!(dcnt[0] > d0 && dcnt[1] > d1) && n < 2000) begin
      tick;
      n++;
      if (ramp && n % 3 == 0 && wrc < 4'd8) wrc = wrc + 4'd1;
      start = restart_busy && n == 3;
    end
    start = 1'b0;
    chk(n < 2000, "pass_timeout", n, 2000);
    chk(dcnt[0] == d0 + 1 && dcnt[1] == d1 + 1, "done_count", dcnt[0] - d0, 1);
  endtask

  initial begin
    int ea [15] = '{0, 1, 2, 1, 2, 3, 2, 3, 4, 3, 4, 5, 4, 5, 6};
    int fb [6] = '{0, 1, 0, 1, 0, 1};
    int d0, n;
    rstn = 1'b0; start = 1'b0; filt_loaded = 1'b0; wrc = 4'd8; rmode = 1'b0;
    dcnt[0] = 0; dcnt[1] = 0;
    newmem;
    repeat (3) tick;
    chk(ov == 2'b00 && rd == 2'b00, "rst_valid_rd", {ov, rd}, 0);
    chk(bsy == 2'b00 && dn == 2'b00, "rst_busy_done", {bsy, dn}, 0);
    chk(ofl[0] == 8'd0 && oif[0] == 8'd0, "rst_data", {ofl[0], oif[0]}, 0);
    chk(olk == 2'b00 && ol == 2'b00 && fa_a == 2'd0 && ia[0] == 3'd0, "rst_tags_addr",
        {olk, ol, fa_a, ia[0]}, 0);
    rstn = 1'b1;
    tick;
    run_pass(1'b0, 1'b0);
    chk(nlog[0] == 15 && nlog[1] == 6, "read_count", nlog[0] * 256 + nlog[1], 15 * 256 + 6);
    for (int j = 0; j < 15; j++) chk(ilog[0][j] == ea[j], "a_if_addr", ilog[0][j], ea[j]);
    for (int j = 0; j < 6; j++) begin
      chk(ilog[1][j] == j, "b_if_addr", ilog[1][j], j);
      chk(flog[1][j] == fb[j], "b_filt_addr", flog[1][j], fb[j]);
    end
    chk(lkm[0] == 16'h4924, "a_last_k_mask", int'(lkm[0]), 16'h4924);
    chk(t1[0] - t0[0] == 14, "a_back_to_back", t1[0] - t0[0], 14);
    chk(t1[1] - t0[1] == 5, "b_back_to_back", t1[1] - t0[1], 5);
    newmem;
    wrc = 4'd0;
    run_pass(1'b1, 1'b0);
    wrc = 4'd8;
    newmem;
    rmode = 1'b1;
    run_pass(1'b0, 1'b0);
    rmode = 1'b0;
    newmem;
    filt_loaded = 1'b1;
    start = 1'b1;
    tick;
    start = 1'b0;
    n = 0;
    while (pc[0] < 6 && n < 500) begin tick; n++; end
    chk(n < 500, "mid_pass_timeout", n, 500);
    d0 = dcnt[0];
    rstn = 1'b0;
    tick;
    chk(ov == 2'b00 && bsy == 2'b00, "reset_mid_pass", {ov, bsy}, 0);
    rstn = 1'b1;
    repeat (20) tick;
    chk(dcnt[0] == d0 && bsy[0] == 1'b0, "no_done_after_reset", dcnt[0] - d0, 0);
    run_pass(1'b0, 1'b0);
    filt_loaded = 1'b0;
    start = 1'b1;
    tick;
    start = 1'b0;
    repeat (5) tick;
    chk(bsy == 2'b00 && rd == 2'b00, "start_without_filter", {bsy, rd}, 0);
    newmem;
    run_pass(1'b0, 1'b1);
    d0 = dcnt[0];
    repeat (30) tick;
    chk(bsy == 2'b00 && dcnt[0] == d0, "start_while_busy", {bsy, 2'(dcnt[0] - d0)}, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
